// File: rtl/de10_peripheral_responder.sv
// DE10 peripheral slave for the tag-0x001 window: LED, synchronized switches,
// down-counting timer with interrupt and a scratch register behind a ready handshake.
module de10_peripheral_responder #(
  parameter int WAIT_STATES = 1,
  parameter int LED_WIDTH   = 10,
  parameter int SW_WIDTH    = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ien,
  input  logic [31:0]          iaddr,
  input  logic                 iwen,
  input  logic [31:0]          iwdata,
  input  logic [SW_WIDTH-1:0]  isw,
  output logic [31:0]          odata,
  output logic                 oready,
  output logic [LED_WIDTH-1:0] oled,
  output logic                 oirq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  localparam logic [3:0] WS_LAST = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

  localparam logic [2:0] OFF_LED     = 3'd0;
  localparam logic [2:0] OFF_SW      = 3'd1;
  localparam logic [2:0] OFF_CTRL    = 3'd2;
  localparam logic [2:0] OFF_LOAD    = 3'd3;
  localparam logic [2:0] OFF_COUNT   = 3'd4;
  localparam logic [2:0] OFF_SCRATCH = 3'd5;

  state_t               r_state;
  logic [3:0]           r_wait_cnt;
  logic [31:0]          r_addr;
  logic                 r_wen;
  logic [31:0]          r_wdata;
  logic                 r_oready;
  logic [31:0]          r_odata;
  logic [LED_WIDTH-1:0] r_led;
  logic [SW_WIDTH-1:0]  r_sw_meta;
  logic [SW_WIDTH-1:0]  r_sw_sync;
  logic                 r_en;
  logic                 r_auto;
  logic                 r_pending;
  logic                 r_irq_en;
  logic [31:0]          r_load;
  logic [31:0]          r_count;
  logic [31:0]          r_scratch;
  logic                 r_irq;

  logic [2:0]           w_rd_off;
  logic [31:0]          w_rdata;
  logic [31:0]          w_led_ext;
  logic [31:0]          w_sw_ext;
  logic                 w_wr_en;
  logic                 w_wr_led;
  logic                 w_wr_ctrl;
  logic                 w_wr_load;
  logic                 w_wr_scratch;
  logic                 w_expire;

  // With zero wait states the response is built on the capture edge, so the live offset is used.
  assign w_rd_off = (r_state == ST_IDLE) ? iaddr[4:2] : r_addr[4:2];

  assign w_wr_en      = (r_state == ST_RESP) && r_wen;
  assign w_wr_led     = w_wr_en && (r_addr[4:2] == OFF_LED);
  assign w_wr_ctrl    = w_wr_en && (r_addr[4:2] == OFF_CTRL);
  assign w_wr_load    = w_wr_en && (r_addr[4:2] == OFF_LOAD);
  assign w_wr_scratch = w_wr_en && (r_addr[4:2] == OFF_SCRATCH);
  assign w_expire     = r_en && (r_count == 32'd0);

  // Zero-extend the narrow LED and switch fields to bus width.
  always_comb begin
    w_led_ext = 32'd0;
    w_led_ext[LED_WIDTH-1:0] = r_led;
    w_sw_ext = 32'd0;
    w_sw_ext[SW_WIDTH-1:0] = r_sw_sync;
  end

  // Register read multiplexer.
  always_comb begin
    w_rdata = 32'd0;
    case (w_rd_off)
      OFF_LED:     w_rdata = w_led_ext;
      OFF_SW:      w_rdata = w_sw_ext;
      OFF_CTRL:    w_rdata = {28'd0, r_irq_en, r_pending, r_auto, r_en};
      OFF_LOAD:    w_rdata = r_load;
      OFF_COUNT:   w_rdata = r_count;
      OFF_SCRATCH: w_rdata = r_scratch;
      default:     w_rdata = 32'd0;
    endcase
  end

  // Access handshake FSM with registered ready/data outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_addr     <= 32'd0;
      r_wen      <= 1'b0;
      r_wdata    <= 32'd0;
      r_oready   <= 1'b0;
      r_odata    <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_oready <= 1'b0;
          r_odata  <= 32'd0;
          if (ien) begin
            r_addr     <= iaddr;
            r_wen      <= iwen;
            r_wdata    <= iwdata;
            r_wait_cnt <= 4'd0;
            if (WAIT_STATES == 0) begin
              r_state  <= ST_RESP;
              r_oready <= 1'b1;
              r_odata  <= iwen ? 32'd0 : w_rdata;
            end else begin
              r_state <= ST_WAIT;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (r_wait_cnt == WS_LAST) begin
            r_state  <= ST_RESP;
            r_oready <= 1'b1;
            r_odata  <= r_wen ? 32'd0 : w_rdata;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        ST_RESP: begin
          r_state  <= ST_HOLD;
          r_oready <= 1'b0;
          r_odata  <= 32'd0;
        end
        ST_HOLD: begin
          r_oready <= 1'b0;
          r_odata  <= 32'd0;
          // Stay here while the master keeps the same request asserted.
          if (!ien || (iaddr != r_addr)) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_HOLD;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_oready <= 1'b0;
          r_odata  <= 32'd0;
        end
      endcase
    end
  end

  // Two-flop synchronizer for the board switches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= isw;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Register file writes and the down-counting timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led     <= '0;
      r_scratch <= 32'd0;
      r_load    <= 32'd0;
      r_count   <= 32'd0;
      r_en      <= 1'b0;
      r_auto    <= 1'b0;
      r_pending <= 1'b0;
      r_irq_en  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr_led) begin
        r_led <= r_wdata[LED_WIDTH-1:0];
      end
      if (w_wr_scratch) begin
        r_scratch <= r_wdata;
      end
      if (w_wr_load) begin
        r_load <= r_wdata;
      end
      // A bus write to EN beats a one-shot expiry clearing it.
      if (w_wr_ctrl) begin
        r_en     <= r_wdata[0];
        r_auto   <= r_wdata[1];
        r_irq_en <= r_wdata[3];
      end else if (w_expire && !r_auto) begin
        r_en <= 1'b0;
      end
      // Expiry beats a simultaneous write-1-to-clear.
      if (w_expire) begin
        r_pending <= 1'b1;
      end else if (w_wr_ctrl && r_wdata[2]) begin
        r_pending <= 1'b0;
      end
      if (w_wr_load) begin
        r_count <= r_wdata;
      end else if (r_en) begin
        if (r_count != 32'd0) begin
          r_count <= r_count - 32'd1;
        end else if (r_auto) begin
          r_count <= r_load;
        end
      end
      r_irq <= r_pending & r_irq_en;
    end
  end

  assign oready = r_oready;
  assign odata  = r_odata;
  assign oled   = r_led;
  assign oirq   = r_irq;

endmodule
